// File: rtl/uart_hex_frame_ctrl.sv
// uart_hex_frame_ctrl: turns '\n'-terminated ASCII-hex lines from the UART
// receiver into framed binary packets on a valid/ready stream. Bad, odd,
// oversized, stalled or overlapping lines are dropped and flagged on err_pulse.
module uart_hex_frame_ctrl #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_byte_en,
   input  logic [7:0] rx_byte,
   output logic       frm_valid,
   input  logic       frm_ready,
   output logic [7:0] frm_data,
   output logic       frm_last,
   output logic [7:0] frm_len,
   output logic       err_pulse,
   output logic [2:0] err_code
);

   localparam int unsigned CW    = $clog2(MAX_LEN + 1);
   localparam int unsigned DEPTH = 1 << CW;

   localparam logic [2:0] E_BADCHAR  = 3'd1;
   localparam logic [2:0] E_ODD      = 3'd2;
   localparam logic [2:0] E_OVERFLOW = 3'd3;
   localparam logic [2:0] E_TIMEOUT  = 3'd4;
   localparam logic [2:0] E_BUSY     = 3'd5;

   typedef enum logic [1:0] {IDLE, COLLECT, DROP, SEND} state_t;

   state_t          state, state_n;
   logic [7:0]      mem [DEPTH];
   logic [CW-1:0]   wcnt, rcnt;
   logic [3:0]      hi_nib, nib;
   logic            half, busy_seen;
   logic [7:0]      len;
   logic [31:0]     tcnt;
   logic            is_hex, is_ws, is_eol, tout_hit, buf_full;
   logic            err_n, ld_hi, clr_w, wr_byte, ld_len, adv_r, set_busy;
   logic [2:0]      code_n;

   // Classify the incoming character and decode its nibble value
   always_comb begin
      is_hex = 1'b0;
      nib    = '0;
      if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
         is_hex = 1'b1;
         nib    = rx_byte[3:0];
      end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                   (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
         is_hex = 1'b1;
         nib    = rx_byte[3:0] + 4'd9;
      end
      is_ws  = (rx_byte == 8'h20) || (rx_byte == 8'h09) || (rx_byte == 8'h0D);
      is_eol = (rx_byte == 8'h0A);
   end

   assign tout_hit = (tcnt >= 32'(TIMEOUT - 1));
   assign buf_full = (wcnt == CW'(MAX_LEN));

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state, error selection and datapath strobes
   always_comb begin
      state_n  = state;
      err_n    = 1'b0;
      code_n   = '0;
      ld_hi    = 1'b0;
      clr_w    = 1'b0;
      wr_byte  = 1'b0;
      ld_len   = 1'b0;
      adv_r    = 1'b0;
      set_busy = 1'b0;
      case (state)
         IDLE: begin
            if (rx_byte_en) begin
               if (is_hex) begin
                  ld_hi   = 1'b1;
                  clr_w   = 1'b1;
                  state_n = COLLECT;
               end else if (!is_ws && !is_eol) begin
                  err_n   = 1'b1;
                  code_n  = E_BADCHAR;
                  state_n = DROP;
               end
            end
         end
         COLLECT: begin
            if (rx_byte_en) begin
               if (is_hex) begin
                  if (half) begin
                     wr_byte = 1'b1;
                  end else if (buf_full) begin
                     err_n   = 1'b1;
                     code_n  = E_OVERFLOW;
                     state_n = DROP;
                  end else begin
                     ld_hi = 1'b1;
                  end
               end else if (is_eol) begin
                  if (half) begin
                     err_n   = 1'b1;
                     code_n  = E_ODD;
                     state_n = IDLE;
                  end else begin
                     ld_len  = 1'b1;
                     state_n = SEND;
                  end
               end else if (!is_ws) begin
                  err_n   = 1'b1;
                  code_n  = E_BADCHAR;
                  state_n = DROP;
               end
            end else if (tout_hit) begin
               err_n   = 1'b1;
               code_n  = E_TIMEOUT;
               state_n = IDLE;
            end
         end
         DROP: begin
            if (rx_byte_en) begin
               if (is_eol) state_n = IDLE;
            end else if (tout_hit) begin
               state_n = IDLE;
            end
         end
         SEND: begin
            if (rx_byte_en && !busy_seen) begin
               err_n    = 1'b1;
               code_n   = E_BUSY;
               set_busy = 1'b1;
            end
            if (frm_ready) begin
               if (frm_last) state_n = IDLE;
               else          adv_r   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Counters, nibble holding register, frame length, idle timer and error outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi_nib    <= '0;
         half      <= 1'b0;
         wcnt      <= '0;
         rcnt      <= '0;
         len       <= '0;
         busy_seen <= 1'b0;
         tcnt      <= '0;
         err_pulse <= 1'b0;
         err_code  <= '0;
      end else begin
         if (ld_hi) begin
            hi_nib <= nib;
            half   <= 1'b1;
            if (clr_w) wcnt <= '0;
         end
         if (wr_byte) begin
            wcnt <= wcnt + CW'(1);
            half <= 1'b0;
         end
         if (ld_len) begin
            len       <= 8'(wcnt);
            rcnt      <= '0;
            busy_seen <= 1'b0;
         end
         if (adv_r)    rcnt      <= rcnt + CW'(1);
         if (set_busy) busy_seen <= 1'b1;
         if (rx_byte_en || state == IDLE || state == SEND) tcnt <= '0;
         else if (tcnt != '1)                              tcnt <= tcnt + 32'd1;
         err_pulse <= err_n;
         if (err_n) err_code <= code_n;
      end
   end

   // Frame buffer write on the low nibble of each pair
   always_ff @(posedge clk) begin
      if (wr_byte) mem[wcnt] <= {hi_nib, nib};
   end

   assign frm_valid = (state == SEND);
   assign frm_data  = frm_valid ? mem[rcnt] : '0;
   assign frm_last  = frm_valid && (8'(rcnt) == (len - 8'd1));
   assign frm_len   = len;

endmodule

// File: tb/tb_uart_hex_frame_ctrl.sv
// tb_uart_hex_frame_ctrl: table vectors, hand-written corner sequences and
// random lines checked against a line-level reference model.
module tb_uart_hex_frame_ctrl;

   localparam int unsigned ML = 4;
   localparam int unsigned TO = 100;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx_byte_en = 1'b0;
   logic [7:0] rx_byte = '0;
   logic       frm_valid, frm_ready, frm_last, err_pulse;
   logic [7:0] frm_data, frm_len;
   logic [2:0] err_code;

   uart_hex_frame_ctrl #(.MAX_LEN(ML), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rstn(rstn), .rx_byte_en(rx_byte_en), .rx_byte(rx_byte),
      .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data),
      .frm_last(frm_last), .frm_len(frm_len), .err_pulse(err_pulse),
      .err_code(err_code)
   );

   int         checks = 0;
   int         errors = 0;
   logic       rand_mode = 1'b0;
   logic       ready_force = 1'b1;
   logic [2:0] obs_err[$];
   logic [2:0] exp_err[$];
   logic [16:0] obs_b[$];
   logic [7:0] exp_b[$];

   typedef struct {
      logic [127:0] txt;
      logic [2:0]   err;
      int unsigned  n;
      logic [31:0]  b;
   } vec_t;
   vec_t tbl[10];

   // Free-running clock
   always #5 clk = ~clk;

   // Downstream ready: forced level or random backpressure
   initial begin
      frm_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         frm_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // Record handshakes and error pulses on the falling edge
   always @(negedge clk) begin
      if (rstn) begin
         if (frm_valid && frm_ready) obs_b.push_back({frm_data, frm_last, frm_len});
         if (err_pulse) obs_err.push_back(err_code);
      end
   end

   // Global watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick_in(input logic en, input logic [7:0] c);
      @(posedge clk);
      #1;
      rx_byte_en = en;
      rx_byte    = c;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick_in(1'b0, 8'h00);
   endtask

   task automatic send_line(input logic [127:0] txt);
      for (int i = 0; i < 16; i++) begin
         if (txt[8*(15-i) +: 8] != 8'h00) tick_in(1'b1, txt[8*(15-i) +: 8]);
      end
      tick_in(1'b0, 8'h00);
   endtask

   task automatic send_q(input logic [7:0] q[$]);
      foreach (q[i]) tick_in(1'b1, q[i]);
      tick_in(1'b1, 8'h0A);
      tick_in(1'b0, 8'h00);
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 500; n++) begin
         @(posedge clk);
         #1;
         if (!frm_valid) begin
            idle(3);
            return;
         end
      end
      chk("drain_bound", 32'(frm_valid), 32'd0);
   endtask

   // Compare everything observed since the last call with the expected events
   task automatic check_q(input string tag);
      int ne, nb;
      chk({tag, ".err_count"}, 32'(obs_err.size()), 32'(exp_err.size()));
      ne = (obs_err.size() < exp_err.size()) ? obs_err.size() : exp_err.size();
      for (int i = 0; i < ne; i++)
         chk($sformatf("%s.err_code[%0d]", tag, i), 32'(obs_err[i]), 32'(exp_err[i]));
      chk({tag, ".byte_count"}, 32'(obs_b.size()), 32'(exp_b.size()));
      nb = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
      for (int i = 0; i < nb; i++)
         chk($sformatf("%s.byte[%0d]{data,last,len}", tag, i), 32'(obs_b[i]),
             32'({exp_b[i], (i == exp_b.size() - 1), 8'(exp_b.size())}));
      obs_err.delete();
      exp_err.delete();
      obs_b.delete();
      exp_b.delete();
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      return -1;
   endfunction

   // Line-level model: digits counted, first offending character wins
   task automatic model_line(input logic [7:0] q[$]);
      int unsigned digits = 0;
      int          v;
      logic [2:0]  e = 3'd0;
      logic [7:0]  digs[$];
      foreach (q[i]) begin
         if (e == 3'd0) begin
            v = hexval(q[i]);
            if (v >= 0) begin
               if (digits == 2 * ML) e = 3'd3;
               else begin
                  digs.push_back(8'(v));
                  digits++;
               end
            end else if (!(q[i] == 8'h20 || q[i] == 8'h09 || q[i] == 8'h0D)) begin
               e = 3'd1;
            end
         end
      end
      if (e != 3'd0)           exp_err.push_back(e);
      else if (digits % 2 == 1) exp_err.push_back(3'd2);
      else
         for (int i = 0; i < digs.size(); i += 2)
            exp_b.push_back(8'(digs[i] * 16 + digs[i+1]));
   endtask

   function automatic logic [7:0] rand_char();
      int r = $urandom_range(0, 99);
      int v;
      if (r < 70) begin
         v = $urandom_range(0, 21);
         if (v < 10)      return 8'(8'h30 + v);
         else if (v < 16) return 8'(8'h61 + v - 10);
         else             return 8'(8'h41 + v - 16);
      end else if (r < 88) begin
         v = $urandom_range(0, 2);
         return (v == 0) ? 8'h20 : (v == 1) ? 8'h09 : 8'h0D;
      end else begin
         v = $urandom_range(0, 3);
         return (v == 0) ? 8'h47 : (v == 1) ? 8'h78 : (v == 2) ? 8'h23 : 8'h2E;
      end
   endfunction

   // Main test sequence
   initial begin
      logic [7:0] q[$];
      int         n;

      tbl[0] = '{128'("0A 1b\r\n"),      3'd0, 2, 32'h0A1B0000};
      tbl[1] = '{128'("12G4\n"),         3'd1, 0, 32'h0};
      tbl[2] = '{128'("FF\n"),           3'd0, 1, 32'hFF000000};
      tbl[3] = '{128'("ABC\n"),          3'd2, 0, 32'h0};
      tbl[4] = '{128'("\n\n"),           3'd0, 0, 32'h0};
      tbl[5] = '{128'("0102030405\n"),   3'd3, 0, 32'h0};
      tbl[6] = '{128'("DEADBEEF\n"),     3'd0, 4, 32'hDEADBEEF};
      tbl[7] = '{128'(" \t7f\r\n"),      3'd0, 1, 32'h7F000000};
      tbl[8] = '{128'("1 2\n"),          3'd0, 1, 32'h12000000};
      tbl[9] = '{128'("zz\n"),           3'd1, 0, 32'h0};

      #2;
      chk("rst.frm_valid", 32'(frm_valid), 32'd0);
      chk("rst.frm_data",  32'(frm_data),  32'd0);
      chk("rst.frm_last",  32'(frm_last),  32'd0);
      chk("rst.frm_len",   32'(frm_len),   32'd0);
      chk("rst.err_pulse", 32'(err_pulse), 32'd0);
      chk("rst.err_code",  32'(err_code),  32'd0);
      idle(2);
      rstn = 1'b1;
      idle(2);

      // Table-driven lines with ready held high
      for (int t = 0; t < 10; t++) begin
         if (tbl[t].err != 3'd0) exp_err.push_back(tbl[t].err);
         for (int j = 0; j < int'(tbl[t].n); j++) exp_b.push_back(tbl[t].b[31-8*j -: 8]);
         send_line(tbl[t].txt);
         wait_drain();
         check_q($sformatf("tbl%0d", t));
      end

      // Backpressure: first byte held for 5 cycles, valid the cycle after '\n'
      ready_force = 1'b0;
      idle(2);
      send_line(128'("0A 1b\r\n"));
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d.valid", i), 32'(frm_valid), 32'd1);
         chk($sformatf("hold%0d.data_last_len", i), 32'({frm_data, frm_last, frm_len}),
             32'({8'h0A, 1'b0, 8'd2}));
         @(posedge clk);
         #1;
      end
      ready_force = 1'b1;
      exp_b.push_back(8'h0A);
      exp_b.push_back(8'h1B);
      wait_drain();
      check_q("hold");

      // Timeout in COLLECT fires after exactly TO silent cycles
      tick_in(1'b1, 8'h31);
      tick_in(1'b1, 8'h32);
      tick_in(1'b0, 8'h00);
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (err_pulse) begin
            n = i;
            break;
         end
      end
      chk("timeout.cycles", 32'(n), 32'(TO));
      chk("timeout.code", 32'(err_code), 32'd4);
      exp_err.push_back(3'd4);
      send_line(128'("34\n"));
      exp_b.push_back(8'h34);
      wait_drain();
      check_q("timeout");

      // Timeout in DROP is silent and returns to IDLE
      tick_in(1'b1, 8'h47);
      tick_in(1'b1, 8'h31);
      idle(150);
      exp_err.push_back(3'd1);
      send_line(128'("56\n"));
      exp_b.push_back(8'h56);
      wait_drain();
      check_q("droptimeout");

      // Bytes arriving during SEND raise BUSY once per frame
      ready_force = 1'b0;
      idle(2);
      send_line(128'("AABB\n"));
      send_line(128'("CC\n"));
      ready_force = 1'b1;
      exp_err.push_back(3'd5);
      exp_b.push_back(8'hAA);
      exp_b.push_back(8'hBB);
      wait_drain();
      check_q("busy1");
      ready_force = 1'b0;
      idle(2);
      send_line(128'("12\n"));
      tick_in(1'b1, 8'h78);
      tick_in(1'b0, 8'h00);
      ready_force = 1'b1;
      exp_err.push_back(3'd5);
      exp_b.push_back(8'h12);
      wait_drain();
      check_q("busy2");

      // Reset mid-SEND drops frm_valid without a clock edge
      ready_force = 1'b0;
      idle(2);
      send_line(128'("0102\n"));
      idle(2);
      chk("prerst.valid", 32'(frm_valid), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst.valid", 32'(frm_valid), 32'd0);
      chk("midrst.data",  32'(frm_data),  32'd0);
      chk("midrst.len",   32'(frm_len),   32'd0);
      idle(2);
      rstn = 1'b1;
      ready_force = 1'b1;
      idle(2);
      send_line(128'("01\n"));
      exp_b.push_back(8'h01);
      wait_drain();
      check_q("afterrst");

      // Random lines with random backpressure against the line model
      rand_mode = 1'b1;
      for (int l = 0; l < 40; l++) begin
         q.delete();
         n = $urandom_range(0, 10);
         for (int i = 0; i < n; i++) q.push_back(rand_char());
         model_line(q);
         send_q(q);
         wait_drain();
         check_q($sformatf("rnd%0d", l));
      end
      rand_mode = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
